add_nbits_seq: RTL

//   Parametrised multi-cycle adder/subtractor for the FP multiplier datapath (mantissa/exponent paths).

---
 rtl/add_pkg.sv | 18 +
 rtl/add_nbits.sv | 29 ++
 rtl/full_adder.sv | 17 +
 rtl/add_nbits_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and helpers for the segmented adder/subtractor.
// Used by the FP multiplier mantissa/exponent paths.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int ceil_div(
    input int a,
    input int b
  );
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/add_nbits.sv
// N-bit combinational ripple-carry adder.
// One instance is time-shared across all segments.
module add_nbits #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_data_one,
  input  logic [N-1:0] i_data_two,
  input  logic         i_carry,
  output logic [N-1:0] o_data,
  output logic         o_carry
);

  logic [N:0] c;

  assign c[0] = i_carry;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .i_a     (i_data_one[i]),
      .i_b     (i_data_two[i]),
      .i_carry (c[i]),
      .o_sum   (o_data[i]),
      .o_carry (c[i+1])
    );
  end

  assign o_carry = c[N];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Building block of the ripple segment adder.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  logic p;

  assign p       = i_a ^ i_b;
  assign o_sum   = p ^ i_carry;
  assign o_carry = (i_a & i_b) | (i_carry & p);

endmodule

// File: rtl/add_nbits_seq.sv
// Multi-cycle add/sub: SEG_W bits per cycle, carry rippled
// through a register between segments, valid/ready on both sides.
module add_nbits_seq
  import add_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int SEG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_one,
  input  logic [WIDTH-1:0] i_data_two,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int SEG_OK = (SEG_W < 1) ? 1 : SEG_W;
  localparam int NSEG   = ceil_div(WIDTH, SEG_OK);
  localparam int PW     = NSEG * SEG_OK;
  localparam int CW     = $clog2(NSEG + 1);

  if (SEG_W < 1 || SEG_W > WIDTH) begin : g_bad_seg
    $error("add_nbits_seq: SEG_W must be in 1..WIDTH");
  end

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    seg;
  logic [PW-1:0]    op_a;
  logic [PW-1:0]    op_b;
  logic [PW-1:0]    res;
  logic [PW-1:0]    res_nxt;
  logic [PW-1:0]    a_pad;
  logic [PW-1:0]    b_pad;
  logic             carry;
  logic             run_q;
  logic             accept;
  logic             step;
  logic             last;
  int               seg_idx;
  logic [SEG_W-1:0] seg_a;
  logic [SEG_W-1:0] seg_b;
  logic [SEG_W-1:0] seg_sum;
  logic             seg_co;
  logic [WIDTH:0]   sum_w;

  // Subtraction is A + ~B + ~borrow; pad bits stay zero.
  always_comb begin
    a_pad = '0;
    b_pad = '0;
    a_pad[WIDTH-1:0] = i_data_one;
    b_pad[WIDTH-1:0] = i_sub ? ~i_data_two : i_data_two;
  end

  assign last    = (seg == CW'(NSEG - 1));
  assign seg_idx = (int'(seg) < NSEG) ? int'(seg) : 0;

  always_comb begin
    seg_a   = op_a[seg_idx*SEG_W +: SEG_W];
    seg_b   = op_b[seg_idx*SEG_W +: SEG_W];
    res_nxt = res;
    res_nxt[seg_idx*SEG_W +: SEG_W] = seg_sum;
  end

  add_nbits #(
    .N (SEG_W)
  ) u_add (
    .i_data_one (seg_a),
    .i_data_two (seg_b),
    .i_carry    (carry),
    .o_data     (seg_sum),
    .o_carry    (seg_co)
  );

  // Bit WIDTH of the padded sum is the true carry-out.
  if (PW == WIDTH) begin : g_full
    assign sum_w = {seg_co, res_nxt};
  end else begin : g_part
    assign sum_w = res_nxt[WIDTH:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = run_q;
        if (i_valid && run_q) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      run_q      <= 1'b0;
      seg        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res        <= '0;
      carry      <= 1'b0;
      o_data     <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        op_a  <= a_pad;
        op_b  <= b_pad;
        carry <= i_carry ^ i_sub;
        seg   <= '0;
      end else if (step) begin
        res   <= res_nxt;
        carry <= seg_co;
        seg   <= seg + CW'(1);
        if (last) begin
          o_data     <= sum_w[WIDTH-1:0];
          o_carry    <= sum_w[WIDTH];
          o_overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                        (sum_w[WIDTH-1] != op_a[WIDTH-1]);
        end
      end
    end
  end

endmodule
